// File: rtl/jk_down_counter_if.sv
// Control/status bundle for jk_down_counter: count/load controls in, count and flags out.
// The counter side uses the slave modport; whoever drives the controls uses master.
interface jk_down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             bin;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             bout;
  logic             tc;

  modport master (
    output en, bin, load, din,
    input  q, bout, tc
  );

  modport slave (
    input  en, bin, load, din,
    output q, bout, tc
  );
endinterface

// File: rtl/jk_down_counter.sv
// Synchronous down counter from per-bit JK stages with load, enable, cascade borrow and reload.
// Define JKDC_SATURATE_EN to hold at zero instead of reloading RELOAD.
module jk_down_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned RELOAD = (1 << WIDTH) - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  jk_down_counter_if.slave      bus
);

  localparam logic [WIDTH-1:0] ReloadVal = WIDTH'(RELOAD);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] low_zero;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j, k;
  logic             cnt;
  logic             zero;
`ifdef JKDC_SATURATE_EN
  logic             one;
`endif

  assign cnt  = bus.en & bus.bin & ~bus.load;
  assign zero = (q_q == '0);
`ifdef JKDC_SATURATE_EN
  assign one  = (q_q == WIDTH'(1));
`endif

  // low_zero[i] is high when every bit below i is zero (the down-count toggle condition).
  always_comb begin
    low_zero    = '0;
    low_zero[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      low_zero[i] = low_zero[i-1] & ~q_q[i-1];
    end
  end

  assign t = {WIDTH{cnt}} & low_zero;

  // Load and reload force each stage through J/K set/reset; otherwise J = K = t.
  always_comb begin
    j = t;
    k = t;
    if (bus.load) begin
      j = bus.din;
      k = ~bus.din;
    end else if (cnt && zero) begin
`ifdef JKDC_SATURATE_EN
      j = '0;
      k = '0;
`else
      j = ReloadVal;
      k = ~ReloadVal;
`endif
    end
  end

  assign q_d = (j & ~q_q) | (~k & q_q);

`ifdef JKDC_SATURATE_EN
  assign tc_d = cnt & one;
`else
  assign tc_d = cnt & zero;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.bout = bus.en & bus.bin & zero;

endmodule

// File: tb/tb_jk_down_counter.sv
// Bench for jk_down_counter: WIDTH=4/RELOAD=9 vector table, reset corner and 8-bit cascade.
module tb_jk_down_counter;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       load;
    logic [3:0] din;
    logic       en;
    logic       bin;
    logic       exp_bout;
    logic [3:0] exp_q;
    logic       exp_tc;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  jk_down_counter_if #(.WIDTH(4)) dut_if ();
  jk_down_counter_if #(.WIDTH(4)) clo ();
  jk_down_counter_if #(.WIDTH(4)) chi ();

  jk_down_counter #(.WIDTH(4), .RELOAD(9)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dut_if)
  );

  jk_down_counter #(.WIDTH(4), .RELOAD(15)) u_lo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (clo)
  );

  jk_down_counter #(.WIDTH(4), .RELOAD(15)) u_hi (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (chi)
  );

  assign chi.bin = clo.bout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic l, input logic [3:0] d, input logic e, input logic b,
                              input logic eb, input logic [3:0] eq, input logic et);
    vecs.push_back('{l, d, e, b, eb, eq, et});
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " q"}, 32'(dut_if.q), 32'(e.q));
      chk({tag, " tc"}, 32'(dut_if.tc), 32'(e.tc));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    dut_if.load = v.load;
    dut_if.din  = v.din;
    dut_if.en   = v.en;
    dut_if.bin  = v.bin;
    #1;
    chk($sformatf("vec%0d bout", idx), 32'(dut_if.bout), 32'(v.exp_bout));
    sb.push_back('{v.exp_q, v.exp_tc});
    @(posedge clk);
    #1;
    pop_check($sformatf("vec%0d", idx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    dut_if.en   = 1'b1;
    dut_if.bin  = 1'b1;
    dut_if.load = 1'b0;
    dut_if.din  = '0;
    clo.en      = 1'b0;
    clo.bin     = 1'b1;
    clo.load    = 1'b0;
    clo.din     = '0;
    chi.en      = 1'b0;
    chi.load    = 1'b0;
    chi.din     = '0;

    #3;
    chk("reset q", 32'(dut_if.q), 32'd0);
    chk("reset tc", 32'(dut_if.tc), 32'd0);
    chk("reset bout", 32'(dut_if.bout), 32'd1);
    @(negedge clk);
    dut_if.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifndef JKDC_SATURATE_EN
    add(0, 4'h0, 1, 1, 1, 4'h9, 1);
    for (int x = 8; x >= 0; x--) add(0, 4'h0, 1, 1, 0, x[3:0], 0);
    add(0, 4'h0, 1, 1, 1, 4'h9, 1);
    add(0, 4'h0, 1, 1, 0, 4'h8, 0);
    add(1, 4'hC, 1, 1, 0, 4'hC, 0);
    for (int x = 11; x >= 5; x--) add(0, 4'h0, 1, 1, 0, x[3:0], 0);
    for (int r = 0; r < 3; r++) add(0, 4'h0, 0, 1, 0, 4'h5, 0);
    for (int r = 0; r < 2; r++) add(0, 4'h0, 1, 0, 0, 4'h5, 0);
    add(1, 4'h0, 0, 1, 0, 4'h0, 0);
    add(0, 4'h0, 1, 0, 0, 4'h0, 0);
    add(0, 4'h0, 0, 1, 0, 4'h0, 0);
    add(1, 4'h3, 1, 1, 1, 4'h3, 0);
    add(0, 4'h0, 1, 1, 0, 4'h2, 0);
`else
    add(1, 4'h2, 1, 1, 1, 4'h2, 0);
    add(0, 4'h0, 1, 1, 0, 4'h1, 0);
    add(0, 4'h0, 1, 1, 0, 4'h0, 1);
    for (int r = 0; r < 3; r++) add(0, 4'h0, 1, 1, 1, 4'h0, 0);
`endif
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a cycle at q=7.
    @(negedge clk);
    dut_if.load = 1'b1;
    dut_if.din  = 4'h7;
    dut_if.en   = 1'b1;
    dut_if.bin  = 1'b1;
    sb.push_back('{4'h7, 1'b0});
    @(posedge clk);
    #1;
    pop_check("pre-reset load");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset q", 32'(dut_if.q), 32'd0);
    chk("async reset tc", 32'(dut_if.tc), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    dut_if.load = 1'b0;
`ifndef JKDC_SATURATE_EN
    sb.push_back('{4'h9, 1'b1});
`else
    sb.push_back('{4'h0, 1'b0});
`endif
    @(posedge clk);
    #1;
    pop_check("post-reset count");

`ifndef JKDC_SATURATE_EN
    // Two 4-bit stages cascaded into one 8-bit counter.
    @(negedge clk);
    dut_if.en = 1'b0;
    clo.load  = 1'b1;
    chi.load  = 1'b1;
    clo.din   = 4'h0;
    chi.din   = 4'h1;
    clo.en    = 1'b1;
    chi.en    = 1'b1;
    @(posedge clk);
    #1;
    chk("cascade load 10", 32'({chi.q, clo.q}), 32'h10);
    @(negedge clk);
    clo.load = 1'b0;
    chi.load = 1'b0;
    #1;
    chk("cascade bout at lo 0", 32'(clo.bout), 32'd1);
    @(posedge clk);
    #1;
    chk("cascade 10->0F", 32'({chi.q, clo.q}), 32'h0F);
    @(negedge clk);
    #1;
    chk("cascade bout at lo F", 32'(clo.bout), 32'd0);
    @(posedge clk);
    #1;
    chk("cascade 0F->0E", 32'({chi.q, clo.q}), 32'h0E);
    @(negedge clk);
    clo.load = 1'b1;
    chi.load = 1'b1;
    clo.din  = 4'h0;
    chi.din  = 4'h0;
    @(posedge clk);
    #1;
    chk("cascade load 00", 32'({chi.q, clo.q}), 32'h00);
    @(negedge clk);
    clo.load = 1'b0;
    chi.load = 1'b0;
    #1;
    chk("cascade bout at 00", 32'(clo.bout), 32'd1);
    @(posedge clk);
    #1;
    chk("cascade 00->FF", 32'({chi.q, clo.q}), 32'hFF);
    chk("cascade hi tc on wrap", 32'(chi.tc), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_down_counter.md
# jk_down_counter

Parameterised synchronous down counter built from per-bit JK flip-flop stages, the count-down companion to the team's 2-bit JK up counter. Every stage shares one clock and toggles when all lower bits are zero, the mirror of the up counter's all-lower-ones rule. Adds synchronous parallel load, count enable, cascade borrow in/out, and modulo reload at zero. Used for timeout, prescaler and down-count sequencing where the up counter cannot serve.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- RELOAD, 2**WIDTH-1: value loaded when the counter decrements from 0; must be < 2**WIDTH.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronised externally.
- en  in  1  count enable.
- bin  in  1  borrow-in for cascading; tie 1 when standalone. Counting requires en & bin.
- load  in  1  synchronous parallel load request.
- din  in  WIDTH  parallel load value.
- q  out  WIDTH  current count.
- bout  out  1  combinational borrow-out: en & bin & (q == 0).
- tc  out  1  registered terminal-count pulse, high for the one cycle after a 0->RELOAD transition.

## Operation
- Each bit i is a JK stage with J = K = t[i].
- t[0] = cnt, where cnt = en & bin & ~load.
- t[i] = cnt & (q[i-1:0] == 0) for i > 0.
- Priority per rising edge: load > count > hold.
- load = 1: q <= din regardless of en/bin. tc <= 0.
- cnt = 1, q != 0: q <= q - 1, via JK toggles only. tc <= 0.
- cnt = 1, q == 0: q <= RELOAD, via JK set/reset override of the stages. tc <= 1.
- cnt = 0 and load = 0: q holds. tc <= 0.
- If RELOAD == 2**WIDTH-1, the reload equals the natural toggle wrap; result is identical.
- Cascade: the low stage's bout drives the high stage's bin, with a shared en. The pair behaves as one 2*WIDTH counter with natural wrap when RELOAD is all-ones.
- din values greater than RELOAD are accepted. The counter counts down from them normally.

## Timing
- Reset (asynchronous, reset = 0): q = 0, tc = 0 immediately. bout = en & bin, since q == 0.
- Latency: q updates one clock after the load or cnt is sampled. bout is combinational from q/en/bin, with zero latency. tc is registered and appears in the cycle after the wrap edge, coincident with q == RELOAD.
- Simultaneous load and count at q == 0: load wins, q <= din, tc <= 0.
- en falling while q == 0: no reload, bout drops the same cycle, q holds 0.
- Reset asserted mid-count or mid-load: the operation is abandoned. The first edge after release acts on q = 0.
- Full period with en held high: RELOAD+1 cycles between tc pulses.

## Configuration
- JKDC_SATURATE_EN
  - Defined: counting at q == 0 holds q at 0 instead of reloading. tc pulses on the edge where q transitions 1 -> 0, and not again while held. bout is unchanged. RELOAD is ignored.
  - Undefined: modulo-reload behaviour exactly as in Operation.

## Test plan
- WIDTH=4, RELOAD=9. Reset, then en=bin=1 for 12 cycles -> q sequence 0,9,8,...,1,0,9. tc high exactly in the cycles q==9 following a wrap.
- load=1, din=4'hC, en=1 in the same cycle, then load=0 -> q=C, then B, A, ... Confirms load priority and over-RELOAD values count down correctly.
- Count to q=5, drop en for 3 cycles -> q holds 5. Then bin=0 with en=1 -> q still holds 5. bout=0 throughout.
- Cascade two WIDTH=4, RELOAD=15 instances. Load 8'h10, count 1 cycle -> 8'h0F. At 8'h00, count 1 -> 8'hFF. Low bout high only when low q==0.
- Assert reset asynchronously mid-cycle at q=7 -> q=0, tc=0 before the next edge. Release, count -> q=RELOAD.
- With JKDC_SATURATE_EN: start from load 2, count 5 cycles -> q 1,0,0,0,0. tc single pulse when q became 0.
